// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register file with two combinational read ports and a valid/ready full-file dump stream
// Optional write-first read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_dump #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 8,
    localparam int ADDR_W   = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_REG,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] Reg_In,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    output logic [DATA_W-1:0] SR1_Out,
    output logic [DATA_W-1:0] SR2_Out,
    input  logic              Dump_Start,
    output logic              Dump_Busy,
    output logic              Dump_Valid,
    input  logic              Dump_Ready,
    output logic [ADDR_W-1:0] Dump_Addr,
    output logic [DATA_W-1:0] Dump_Data,
    output logic              Dump_Last
);

    localparam logic [ADDR_W:0]   LP_COUNT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_valid;
    logic              r_busy;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_wr_en;
    logic              w_sr1_ok;
    logic              w_sr2_ok;
    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_sr1;
    logic [DATA_W-1:0] w_sr2;

    assign w_wr_en     = LD_REG && ({1'b0, DR} < LP_COUNT);
    assign w_sr1_ok    = {1'b0, SR1} < LP_COUNT;
    assign w_sr2_ok    = {1'b0, SR2} < LP_COUNT;
    assign w_next_addr = r_addr + ADDR_W'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[DR] <= Reg_In;
        end
    end

    // Out-of-range indices read as all-ones; the bypass only covers in-range writes.
    always_comb begin
        w_sr1 = '1;
        if (w_sr1_ok) begin
            w_sr1 = r_regs[SR1];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (SR1 == DR)) begin
            w_sr1 = Reg_In;
        end
`endif
    end

    always_comb begin
        w_sr2 = '1;
        if (w_sr2_ok) begin
            w_sr2 = r_regs[SR2];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (SR2 == DR)) begin
            w_sr2 = Reg_In;
        end
`endif
    end

    assign SR1_Out = w_sr1;
    assign SR2_Out = w_sr2;

    // Beat data is captured from the pre-edge array, so a same-edge write never leaks into the stream.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Dump_Start) begin
                        r_state <= SEND;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= 1'b0;
                        r_addr  <= '0;
                        r_data  <= r_regs[0];
                    end
                end
                SEND: begin
                    if (Dump_Ready) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_addr  <= '0;
                            r_data  <= '0;
                        end else begin
                            r_addr <= w_next_addr;
                            r_data <= r_regs[w_next_addr];
                            r_last <= (w_next_addr == LP_LAST);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Dump_Busy  = r_busy;
    assign Dump_Valid = r_valid;
    assign Dump_Addr  = r_addr;
    assign Dump_Data  = r_data;
    assign Dump_Last  = r_last;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump (8x16 default instance plus a 6x32 instance)
module tb_regfile_dump;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        LD_REG = 1'b0;
    logic [2:0]  DR = '0;
    logic [15:0] Reg_In = '0;
    logic [2:0]  SR1 = '0;
    logic [2:0]  SR2 = '0;
    logic [15:0] SR1_Out, SR2_Out;
    logic        Dump_Start = 1'b0;
    logic        Dump_Busy, Dump_Valid;
    logic        Dump_Ready = 1'b0;
    logic [2:0]  Dump_Addr;
    logic [15:0] Dump_Data;
    logic        Dump_Last;

    logic        b_ld = 1'b0;
    logic [2:0]  b_dr = '0;
    logic [31:0] b_in = '0;
    logic [2:0]  b_sr1 = '0;
    logic [2:0]  b_sr2 = '0;
    logic [31:0] b_sr1_out, b_sr2_out;
    logic        b_start = 1'b0;
    logic        b_busy, b_valid;
    logic        b_ready = 1'b0;
    logic [2:0]  b_addr;
    logic [31:0] b_data;
    logic        b_last;

    int n_checks = 0;
    int n_errors = 0;
    bit run_cmp  = 1'b0;

    always #5 Clk = ~Clk;

    regfile_dump #(.DATA_W(16), .NUM_REGS(8)) dut (
        .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .Reg_In(Reg_In),
        .SR1(SR1), .SR2(SR2), .SR1_Out(SR1_Out), .SR2_Out(SR2_Out),
        .Dump_Start(Dump_Start), .Dump_Busy(Dump_Busy), .Dump_Valid(Dump_Valid),
        .Dump_Ready(Dump_Ready), .Dump_Addr(Dump_Addr), .Dump_Data(Dump_Data),
        .Dump_Last(Dump_Last)
    );

    regfile_dump #(.DATA_W(32), .NUM_REGS(6)) dut_b (
        .Clk(Clk), .Reset(Reset), .LD_REG(b_ld), .DR(b_dr), .Reg_In(b_in),
        .SR1(b_sr1), .SR2(b_sr2), .SR1_Out(b_sr1_out), .SR2_Out(b_sr2_out),
        .Dump_Start(b_start), .Dump_Busy(b_busy), .Dump_Valid(b_valid),
        .Dump_Ready(b_ready), .Dump_Addr(b_addr), .Dump_Data(b_data),
        .Dump_Last(b_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: register contents plus the dump as "which beat is on offer and what was snapshotted".
    logic [15:0] mreg [8];
    bit          m_busy = 1'b0;
    int          m_idx  = 0;
    logic [15:0] m_data = '0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) mreg[i] = '0;
            m_busy = 1'b0;
            m_idx  = 0;
            m_data = '0;
        end else begin
            if (!m_busy) begin
                if (Dump_Start) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                    m_data = mreg[0];
                end
            end else if (Dump_Ready) begin
                if (m_idx == 7) begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                    m_data = '0;
                end else begin
                    m_idx  = m_idx + 1;
                    m_data = mreg[m_idx];
                end
            end
            if (LD_REG) mreg[DR] = Reg_In;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [2:0] idx);
        if (BYP && LD_REG && (DR == idx)) return Reg_In;
        return mreg[idx];
    endfunction

    logic [2:0]  log_addr [16];
    logic [15:0] log_data [16];
    logic        log_last [16];
    int          log_n = 0;

    always @(negedge Clk) begin
        if (run_cmp) begin
            chk("sr1_out", 32'(SR1_Out), 32'(exp_rd(SR1)));
            chk("sr2_out", 32'(SR2_Out), 32'(exp_rd(SR2)));
            chk("dump_valid", 32'(Dump_Valid), 32'(m_busy));
            chk("dump_busy", 32'(Dump_Busy), 32'(m_busy));
            chk("dump_addr", 32'(Dump_Addr), 32'(m_busy ? m_idx : 0));
            chk("dump_data", 32'(Dump_Data), 32'(m_data));
            chk("dump_last", 32'(Dump_Last), 32'(m_busy && (m_idx == 7)));
            if (Dump_Valid && Dump_Ready && (log_n < 16)) begin
                log_addr[log_n] = Dump_Addr;
                log_data[log_n] = Dump_Data;
                log_last[log_n] = Dump_Last;
                log_n++;
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    initial begin
        int k, cnt, nlast;
        logic [2:0]  last_addr;
        logic [31:0] last_data;

        #1 Reset = 1'b0;
        run_cmp = 1'b1;
        tick;
        #2;
        chk("rst_valid", 32'(Dump_Valid), 32'h0);
        chk("rst_sr1", 32'(SR1_Out), 32'h0);
        tick;
        Reset = 1'b1;

        // Write R3 and read it on both ports
        LD_REG = 1'b1; DR = 3'd3; Reg_In = 16'h1234;
        tick;
        LD_REG = 1'b0; SR1 = 3'd3; SR2 = 3'd3;
        #2;
        chk("wr_sr1", 32'(SR1_Out), 32'h1234);
        chk("wr_sr2", 32'(SR2_Out), 32'h1234);
        SR2 = 3'd4;
        #1;
        chk("wr_other", 32'(SR2_Out), 32'h0);

        // Write-first bypass vs pre-write value
        tick;
        LD_REG = 1'b1; DR = 3'd5; Reg_In = 16'hBEEF; SR1 = 3'd5;
        #2;
        chk("bypass", 32'(SR1_Out), BYP ? 32'hBEEF : 32'h0000);
        tick;
        LD_REG = 1'b0;
        #1;
        chk("after_write", 32'(SR1_Out), 32'hBEEF);

        // Preload Rn = n*0x0101
        for (int n = 0; n < 8; n++) begin
            LD_REG = 1'b1; DR = 3'(n); Reg_In = 16'(n * 16'h0101);
            tick;
        end
        LD_REG = 1'b0;

        // Full dump with Dump_Ready held high
        log_n = 0;
        Dump_Ready = 1'b1; Dump_Start = 1'b1;
        tick;
        Dump_Start = 1'b0;
        #2;
        chk("beat0_valid", 32'(Dump_Valid), 32'h1);
        chk("beat0_addr", 32'(Dump_Addr), 32'h0);
        for (k = 0; k < 30 && log_n < 8; k++) tick;
        chk("full_beats", 32'(log_n), 32'd8);
        #2;
        chk("full_busy_after", 32'(Dump_Busy), 32'h0);
        chk("full_valid_after", 32'(Dump_Valid), 32'h0);
        nlast = 0;
        for (int b = 0; b < 8; b++) begin
            chk("full_addr", 32'(log_addr[b]), 32'(b));
            chk("full_data", 32'(log_data[b]), 32'(b * 32'h0101));
            if (log_last[b]) nlast++;
        end
        chk("full_last_count", 32'(nlast), 32'd1);
        chk("full_last_on7", 32'(log_last[7]), 32'h1);

        // Back-pressure at beat 2 with a concurrent write to R2 and an ignored Dump_Start
        tick;
        log_n = 0;
        Dump_Ready = 1'b1; Dump_Start = 1'b1;
        tick;
        Dump_Start = 1'b0;
        for (k = 0; k < 20 && Dump_Addr != 3'd2; k++) tick;
        chk("bp_reach", 32'(Dump_Addr), 32'd2);
        Dump_Ready = 1'b0; LD_REG = 1'b1; DR = 3'd2; Reg_In = 16'hFFFF; Dump_Start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            LD_REG = 1'b0; Dump_Start = 1'b0;
            #2;
            chk("bp_hold_data", 32'(Dump_Data), 32'h0202);
            chk("bp_hold_addr", 32'(Dump_Addr), 32'd2);
        end
        Dump_Ready = 1'b1;
        tick;
        #2;
        chk("bp_resume_addr", 32'(Dump_Addr), 32'd3);
        chk("bp_resume_data", 32'(Dump_Data), 32'h0303);
        for (k = 0; k < 30 && log_n < 8; k++) tick;
        chk("bp_beats", 32'(log_n), 32'd8);
        chk("bp_beat2_data", 32'(log_data[2]), 32'h0202);
        SR1 = 3'd2;
        #1;
        chk("bp_r2_new", 32'(SR1_Out), 32'hFFFF);

        // Reset in the middle of a dump
        tick;
        Dump_Ready = 1'b1; Dump_Start = 1'b1;
        tick;
        Dump_Start = 1'b0;
        for (k = 0; k < 20 && Dump_Addr != 3'd4; k++) tick;
        chk("rst_reach", 32'(Dump_Addr), 32'd4);
        SR1 = 3'd3; SR2 = 3'd7;
        Reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(Dump_Valid), 32'h0);
        chk("mid_rst_busy", 32'(Dump_Busy), 32'h0);
        chk("mid_rst_data", 32'(Dump_Data), 32'h0);
        chk("mid_rst_r3", 32'(SR1_Out), 32'h0);
        chk("mid_rst_r7", 32'(SR2_Out), 32'h0);
        tick;
        Reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("no_resume", 32'(Dump_Valid), 32'h0);
        end
        Dump_Start = 1'b1;
        tick;
        Dump_Start = 1'b0;
        #1;
        chk("restart_valid", 32'(Dump_Valid), 32'h1);
        for (k = 0; k < 20 && Dump_Busy; k++) tick;
        chk("restart_done", 32'(Dump_Busy), 32'h0);

        // 6 x 32 instance: range handling and a 6-beat dump
        b_sr1 = 3'd7; b_sr2 = 3'd6;
        #1;
        chk("b_rd7", b_sr1_out, 32'hFFFFFFFF);
        chk("b_rd6", b_sr2_out, 32'hFFFFFFFF);
        b_ld = 1'b1; b_dr = 3'd6; b_in = 32'hDEADBEEF;
        tick;
        b_ld = 1'b0;
        for (int n = 0; n < 6; n++) begin
            b_sr1 = 3'(n);
            #1;
            chk("b_oob_write", b_sr1_out, 32'h0);
        end
        b_ld = 1'b1; b_dr = 3'd5; b_in = 32'h0000_0005;
        tick;
        b_ld = 1'b0; b_ready = 1'b1; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        cnt = 0; nlast = 0; last_addr = '0; last_data = '0;
        for (k = 0; k < 20 && b_busy; k++) begin
            #2;
            if (b_valid) begin
                cnt++;
                last_addr = b_addr;
                last_data = b_data;
                if (b_last) nlast++;
            end
            tick;
        end
        chk("b_beats", 32'(cnt), 32'd6);
        chk("b_last_addr", 32'(last_addr), 32'd5);
        chk("b_last_data", last_data, 32'h5);
        chk("b_last_count", 32'(nlast), 32'd1);

        tick;
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
